// File: rtl/spmv_csr_engine.sv
// Sparse matrix-vector multiply engine for CSR-encoded matrices.
// A pointer table is captured on start, then (value, vector) pairs stream in
// one per cycle. Each pair goes through a two-stage multiply/accumulate
// pipeline into a per-row saturating accumulator.
module spmv_csr_engine #(
  parameter int ROWS   = 16,
  parameter int PTR_W  = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [(ROWS+1)*PTR_W-1:0]   i_row_ptr,
  input  logic                        i_a_valid,
  output logic                        o_a_ready,
  input  logic [DATA_W-1:0]           i_a_data,
  input  logic [DATA_W-1:0]           i_x_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ROWS*ACC_W-1:0]       o_result,
  output logic [ROWS-1:0]             o_row_valid,
  output logic                        o_sat,
  output logic                        o_err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = 2 * DATA_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Architectural state
  logic [1:0]              state_q, state_d;
  logic [PTR_W-1:0]        ptr_q [ROWS+1];
  logic [PTR_W-1:0]        ptr_d [ROWS+1];
  logic [PTR_W-1:0]        nnz_q, nnz_d;
  logic [PTR_W-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]           row_q, row_d;

  // Pipeline stage 1: registered product tagged with its row
  logic                    p1_valid_q, p1_valid_d;
  logic [PW-1:0]           p1_prod_q, p1_prod_d;
  logic [RW-1:0]           p1_row_q, p1_row_d;
  logic                    p1_last_q, p1_last_d;

  // Accumulators and status
  logic [ACC_W-1:0]        acc_q [ROWS];
  logic [ACC_W-1:0]        acc_d [ROWS];
  logic [ROWS-1:0]         row_valid_q, row_valid_d;
  logic                    sat_q, sat_d;
  logic                    err_q, err_d;

  // Combinational helpers
  logic [PTR_W-1:0]        rel_end [ROWS];
  logic                    ptr_bad;
  logic                    accept;
  logic [PTR_W-1:0]        search_e;
  logic [RW-1:0]           next_row;
  logic                    row_last;
  logic [PW-1:0]           prod_w;
  logic [ACC_W:0]          sum_w;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        sum_sat;

  assign o_a_ready = (state_q == ST_RUN) && (cnt_q < nnz_q);
  assign accept    = i_a_valid && o_a_ready;
  assign o_busy    = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign o_done    = (state_q == ST_DONE);
  assign o_row_valid = row_valid_q;
  assign o_sat     = sat_q;
  assign o_err     = err_q;

  assign prod_w = PW'($signed(i_a_data)) * PW'($signed(i_x_data));

  // Row end offsets relative to ptr[0], and a monotonicity check on the table
  always_comb begin
    ptr_bad = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      rel_end[r] = ptr_q[r+1] - ptr_q[0];
      if (ptr_q[r+1] < ptr_q[r]) ptr_bad = 1'b1;
    end
  end

  // Row owning the next element: first row whose end offset lies beyond it,
  // which naturally steps over any run of empty rows in a single cycle
  always_comb begin
    search_e = (state_q == ST_LOAD) ? '0 : cnt_q + PTR_W'(1);
    next_row = RW'(ROWS - 1);
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (rel_end[r] > search_e) next_row = RW'(r);
    end
    row_last = ((cnt_q + PTR_W'(1)) == rel_end[row_q]);
  end

  // Stage-2 saturating add of the tagged product into its row accumulator
  always_comb begin
    sum_w   = {acc_q[p1_row_q][ACC_W-1], acc_q[p1_row_q]}
            + {{(ACC_W+1-PW){p1_prod_q[PW-1]}}, p1_prod_q};
    sum_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    if (!sum_ovf)          sum_sat = sum_w[ACC_W-1:0];
    else if (sum_w[ACC_W]) sum_sat = ACC_MIN;
    else                   sum_sat = ACC_MAX;
  end

  // Next-state logic for the FSM, pipeline and accumulators
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    nnz_d       = nnz_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    p1_valid_d  = p1_valid_q;
    p1_prod_d   = p1_prod_q;
    p1_row_d    = p1_row_q;
    p1_last_d   = p1_last_q;
    acc_d       = acc_q;
    row_valid_d = row_valid_q;
    sat_d       = sat_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          for (int k = 0; k <= ROWS; k++) ptr_d[k] = i_row_ptr[k*PTR_W +: PTR_W];
          for (int r = 0; r < ROWS; r++) acc_d[r] = '0;
          row_valid_d = '0;
          sat_d       = 1'b0;
          err_d       = 1'b0;
          cnt_d       = '0;
          row_d       = '0;
          nnz_d       = '0;
          p1_valid_d  = 1'b0;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        nnz_d = ptr_q[ROWS] - ptr_q[0];
        if (ptr_bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          for (int r = 0; r < ROWS; r++) begin
            if (ptr_q[r+1] == ptr_q[r]) row_valid_d[r] = 1'b1;
          end
          row_d   = next_row;
          state_d = (ptr_q[ROWS] == ptr_q[0]) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (p1_valid_q) begin
          acc_d[p1_row_q] = sum_sat;
          if (sum_ovf)   sat_d = 1'b1;
          if (p1_last_q) row_valid_d[p1_row_q] = 1'b1;
        end
        p1_valid_d = accept;
        if (accept) begin
          p1_prod_d = prod_w;
          p1_row_d  = row_q;
          p1_last_d = row_last;
          cnt_d     = cnt_q + PTR_W'(1);
          row_d     = next_row;
        end
        // With every pair accepted, the product now in stage 1 is the last one
        if (p1_valid_q && (cnt_q == nnz_q)) state_d = ST_DONE;
      end

      default: begin
        p1_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      for (int k = 0; k <= ROWS; k++) ptr_q[k] <= '0;
      nnz_q       <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      p1_valid_q  <= 1'b0;
      p1_prod_q   <= '0;
      p1_row_q    <= '0;
      p1_last_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
      row_valid_q <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      nnz_q       <= nnz_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      p1_valid_q  <= p1_valid_d;
      p1_prod_q   <= p1_prod_d;
      p1_row_q    <= p1_row_d;
      p1_last_q   <= p1_last_d;
      acc_q       <= acc_d;
      row_valid_q <= row_valid_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
    end
  end

  // Flatten the accumulator array onto the packed result bus
  always_comb begin
    o_result = '0;
    for (int r = 0; r < ROWS; r++) o_result[r*ACC_W +: ACC_W] = acc_q[r];
  end

endmodule

// File: doc/spmv_csr_engine.md
SPMV_CSR_ENGINE -- requirements
Module: spmv_csr_engine

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- ROWS, 16, number of output rows.
- PTR_W, 8, width of each CSR row pointer.
- DATA_W, 16, width of each signed two's-complement operand.
- ACC_W, 32, width of each signed row accumulator; ACC_W >= 2*DATA_W.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports are listed one per line: name, direction, width, meaning.
- i_clk, in, 1, clock; rising edge active.
- i_rstn, in, 1, asynchronous active-low reset.
- i_start, in, 1, start pulse; sampled in IDLE only.
- i_row_ptr, in, (ROWS+1)*PTR_W, CSR row pointers; ptr[k] is bits [k*PTR_W +: PTR_W].
- i_a_valid, in, 1, nonzero pair valid.
- o_a_ready, out, 1, engine accepts a pair.
- i_a_data, in, DATA_W, nonzero matrix value.
- i_x_data, in, DATA_W, matching vector element.
- o_busy, out, 1, high in LOAD and RUN.
- o_done, out, 1, one-cycle completion pulse.
- o_result, out, ROWS*ACC_W, row r result at bits [r*ACC_W +: ACC_W].
- o_row_valid, out, ROWS, row r result is final.
- o_sat, out, 1, sticky: an accumulator saturated.
- o_err, out, 1, sticky: pointer table invalid.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-004 In IDLE, i_start=1 SHALL do all of the following on the same edge: capture i_row_ptr; clear o_result, o_row_valid, o_sat and o_err; clear the element counter and the row index; enter LOAD.
REQ-005 While in LOAD, RUN or DONE, i_start SHALL be ignored.
REQ-006 LOAD SHALL last exactly one cycle and check the captured pointers.
- If any ptr[k+1] < ptr[k], LOAD SHALL set o_err and go to DONE.
- Else, if ptr[ROWS] == ptr[0], LOAD SHALL go to DONE.
- Otherwise LOAD SHALL go to RUN.
- In every case, LOAD SHALL set NNZ = ptr[ROWS] - ptr[0].
REQ-007 In RUN, o_a_ready SHALL be 1 while the element counter < NNZ, and 0 otherwise.
- A pair is accepted on any edge where i_a_valid and o_a_ready are both 1.
REQ-008 Each accepted pair SHALL be multiplied as signed operands into a 2*DATA_W product register (pipeline stage 1).
- The product SHALL be tagged with its row index.
- The product SHALL be sign-extended and added into that row's accumulator on the next edge (stage 2).
REQ-009 The row index for element e (counted from 0) SHALL be the smallest r with ptr[r+1] - ptr[0] > e.
- Empty rows SHALL be skipped with no stall.
- Throughput SHALL be one pair per cycle.
REQ-010 Accumulation SHALL saturate to the ACC_W signed maximum or minimum on overflow.
- o_sat SHALL set on the edge where saturation occurs and stay set until the next start.
REQ-011 o_row_valid[r] SHALL set on the edge where the last product of row r is added.
- Empty rows SHALL set on leaving LOAD, or on entering DONE if LOAD goes to DONE.
REQ-012 RUN SHALL go to DONE on the edge after the stage-2 add of element NNZ-1.
- o_done SHALL be 1 during the single DONE cycle, exactly 2 cycles after the last handshake.
- DONE SHALL return to IDLE unconditionally.
REQ-013 In DONE, every bit of o_row_valid SHALL be 1.
- Exception: when o_err is set, o_row_valid SHALL stay 0.
REQ-014 o_result, o_sat and o_err SHALL hold their values in IDLE until the next accepted start.
REQ-015 i_a_valid arriving outside RUN SHALL be ignored, with no side effects.
REQ-016 An idle cycle (i_a_valid=0) in RUN SHALL stall the engine with no state change, except that pipeline stage 2 drains.

Reset
REQ-017 While i_rstn=0, the block SHALL immediately, regardless of clock:
- set the FSM to IDLE;
- set o_a_ready, o_busy, o_done, o_sat, o_err, o_row_valid and o_result to 0;
- clear both pipeline stages, the counter and the row index.
REQ-018 Reset asserted mid-RUN SHALL discard partial results.
- After release, the first start SHALL behave as from power-up.

Verification
REQ-019 The bench SHALL cover these scenarios with ROWS=16, PTR_W=8, DATA_W=16 and ACC_W=32:
- ptr[0..16] = 00,00,01,02,02,03,04,04,04,07,07,07,07,09,09,09,0A, with 10 back-to-back pairs a=16, x=2 -> rows 1, 2, 4, 5 and 15 = 32; row 8 = 96; row 12 = 64; all other rows = 0; o_done 2 cycles after the 10th handshake; o_row_valid = FFFF.
- Same table with i_a_valid dropped for 3 cycles after pair 4 -> identical results; o_a_ready stays 1 through the gap.
- All pointers 05 -> LOAD goes to DONE; o_done 2 cycles after start; results 0; o_row_valid = FFFF; o_a_ready never 1.
- ptr[3]=04, ptr[4]=02 -> o_err=1, o_done pulses, o_row_valid = 0000.
- Row 0 with 3 pairs a=7FFF, x=7FFF (ptr[1]=03, rest 03) -> row 0 saturates at 7FFFFFFF; o_sat=1.
- i_rstn low after pair 5 of scenario 1 -> all outputs 0 immediately; a new start then reproduces scenario 1 exactly; i_start pulsed mid-RUN has no effect.
